// File: rtl/tff_toggle_scheduler_pkg.sv
// rtl/tff_toggle_scheduler_pkg.sv - shared constants and enums for the toggle scheduler
package tff_toggle_scheduler_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_TOGGLE = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_SET    = 2'b11
    } op_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/tff_toggle_scheduler_if.sv
// rtl/tff_toggle_scheduler_if.sv - request/grant and status bundle of the toggle scheduler
interface tff_toggle_scheduler_if;
    import tff_toggle_scheduler_pkg::*;

    logic [NREQ-1:0]   req_val;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_rdy;
    logic              q;
    logic [3:0]        tog_count;
    logic [1:0]        last_grant;
    logic              locked;

    modport master (
        output req_val, req_op,
        input  req_rdy, q, tog_count, last_grant, locked
    );

    modport slave (
        input  req_val, req_op,
        output req_rdy, q, tog_count, last_grant, locked
    );
endinterface

// File: rtl/tff_toggle_scheduler_rr_arbiter4.sv
// rtl/tff_toggle_scheduler_rr_arbiter4.sv - four-way combinational round-robin grant
module rr_arbiter4
    import tff_toggle_scheduler_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [NREQ-1:0] gnt
);

    logic [1:0] idx;
    logic       found;

    // Search upward from ptr; the 2-bit index wraps 3 -> 0 naturally.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + k[1:0];
            if (req[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tff_toggle_scheduler.sv
// rtl/tff_toggle_scheduler.sv - round-robin scheduler driving one shared toggle flip-flop
module tff_toggle_scheduler
    import tff_toggle_scheduler_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    tff_toggle_scheduler_if.slave   bus
);

    state_t          state, state_nx;
    logic [1:0]      ptr, ptr_nx;
    logic            q_r, q_nx;
    logic [3:0]      cnt_r, cnt_nx;
    logic [1:0]      last_r, last_nx;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] rdy;
    logic [1:0]      idx;
    logic            xfer;
    op_t             op;

    rr_arbiter4 u_arb (
        .req (bus.req_val),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        rdy      = '0;
        idx      = 2'd0;
        xfer     = 1'b0;
        op       = OP_HOLD;
        q_nx     = q_r;
        cnt_nx   = cnt_r;
        ptr_nx   = ptr;
        last_nx  = last_r;
        state_nx = ST_RUN;

        // Grants are masked while reset is held so nothing leaks out during reset.
        if (reset && state == ST_RUN)
            rdy = gnt;

        for (int i = 0; i < NREQ; i++)
            if (rdy[i]) idx = i[1:0];

        xfer = |(rdy & bus.req_val);
        op   = op_t'(bus.req_op[{idx, 1'b0} +: 2]);

        if (state == ST_RUN && xfer) begin
            unique case (op)
                OP_HOLD:   q_nx = q_r;
                OP_TOGGLE: q_nx = ~q_r;
                OP_CLEAR:  q_nx = 1'b0;
                OP_SET:    q_nx = 1'b1;
            endcase
            ptr_nx  = idx + 2'd1;
            last_nx = idx;
            if (op == OP_CLEAR || op == OP_SET)
                state_nx = ST_LOCK;
        end

        if (q_nx != q_r && cnt_r != 4'hf)
            cnt_nx = cnt_r + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            ptr    <= 2'd0;
            q_r    <= 1'b0;
            cnt_r  <= 4'd0;
            last_r <= 2'd0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            q_r    <= q_nx;
            cnt_r  <= cnt_nx;
            last_r <= last_nx;
        end
    end

    assign bus.req_rdy    = rdy;
    assign bus.q          = q_r;
    assign bus.tog_count  = cnt_r;
    assign bus.last_grant = last_r;
    assign bus.locked     = (state == ST_LOCK);

endmodule
